// File: rtl/fat32_volume_probe_pkg.sv
// ============================================================================
// Module   : fat32_probe_pkg
// Purpose  : Shared types and constants for the FAT32 volume probe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fat32_probe_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_MBR  = 3'd1,
        ST_CHK_MBR = 3'd2,
        ST_RD_BPB  = 3'd3,
        ST_CHK_BPB = 3'd4,
        ST_CALC    = 3'd5,
        ST_FIN     = 3'd6,
        ST_FAIL    = 3'd7
    } probe_state_e;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_MBR_SIG  = 3'd1;
    localparam logic [2:0] ERR_PTYPE    = 3'd2;
    localparam logic [2:0] ERR_BPB_SIG  = 3'd3;
    localparam logic [2:0] ERR_BPS      = 3'd4;
    localparam logic [2:0] ERR_SPC      = 3'd5;
    localparam logic [2:0] ERR_FATS     = 3'd6;
    localparam logic [2:0] ERR_OVERFLOW = 3'd7;

    localparam int OFS_JMP      = 'h000;
    localparam int OFS_SIG0     = 'h1FE;
    localparam int OFS_PTYPE    = 'h1C2;
    localparam int OFS_PLBA     = 'h1C6;
    localparam int OFS_BPS      = 'h00B;
    localparam int OFS_SPC      = 'h00D;
    localparam int OFS_RSVD     = 'h00E;
    localparam int OFS_NFATS    = 'h010;
    localparam int OFS_FATSZ    = 'h024;
    localparam int OFS_ROOTCLUS = 'h02C;

    localparam logic [7:0]  PTYPE_FAT32_CHS = 8'h0B;
    localparam logic [7:0]  PTYPE_FAT32_LBA = 8'h0C;
    localparam logic [7:0]  JMP_SHORT       = 8'hEB;
    localparam logic [7:0]  JMP_NEAR        = 8'hE9;
    localparam logic [15:0] BOOT_SIG        = 16'hAA55;
    localparam logic [15:0] SECTOR_BYTES    = 16'd512;

    function automatic logic is_pow2(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fat32_volume_probe_if.sv
// ============================================================================
// Module   : fat32_volume_probe_if
// Purpose  : Sector-reader bus between the probe (master) and SPI reader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fat32_volume_probe_if;
    logic        rd_start;
    logic [31:0] rd_sector_no;
    logic        rd_done;
    logic        rvalid;
    logic [8:0]  raddr;
    logic [7:0]  rdata;

    modport master (output rd_start, rd_sector_no, input rd_done, rvalid, raddr, rdata);
    modport slave  (input rd_start, rd_sector_no, output rd_done, rvalid, raddr, rdata);
endinterface

`default_nettype wire

// File: rtl/fat32_volume_probe_capture.sv
// ============================================================================
// Module   : le32_field_capture
// Purpose  : Little-endian field grabber; each byte lane keyed by raddr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module le32_field_capture
    import fat32_probe_pkg::*;
#(
    parameter int OFFSET = 0,
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic [8:0]            addr_i,
    input  logic [7:0]            data_i,
    output logic [8*NBYTES-1:0]   value_o
);

    logic [7:0] lane_q [NBYTES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBYTES; i++) lane_q[i] <= 8'd0;
        end else if (clr_i) begin
            for (int i = 0; i < NBYTES; i++) lane_q[i] <= 8'd0;
        end else if (en_i) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (addr_i == 9'(OFFSET + i)) lane_q[i] <= data_i;
            end
        end
    end

    generate
        for (genvar g = 0; g < NBYTES; g++) begin : g_out
            assign value_o[8*g +: 8] = lane_q[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/fat32_volume_probe.sv
// ============================================================================
// Module   : fat32_volume_probe
// Purpose  : Reads MBR then FAT32 BPB, validates both, derives volume geometry.
//            Option FAT32_PROBE_SUPERFLOPPY_EN accepts a BPB directly in sector 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fat32_volume_probe
    import fat32_probe_pkg::*;
#(
    parameter int MAX_RETRY = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        probe_start_i,
    fat32_volume_probe_if.master        rd,
    output logic                        busy_o,
    output logic                        done_o,
    output logic                        error_o,
    output logic [2:0]                  err_code_o,
    output logic [31:0]                 part_lba_o,
    output logic [31:0]                 fat_lba_o,
    output logic [31:0]                 data_lba_o,
    output logic [31:0]                 root_clus_o,
    output logic [7:0]                  sec_per_clus_o
);

    probe_state_e state_q, state_d;
    logic [31:0]  part_q, part_d, fat_q, data_q;
    logic [7:0]   cnt_q, retry_q;
    logic [2:0]   err_q, err_d;
    logic         busy_q, done_q, error_q;
    logic         accept, clr_cap, load_fat, do_add, fin, fail_final, retry, set_err;

    logic [15:0]  w_sig, w_bps, w_rsvd;
    logic [7:0]   w_ptype, w_spc, w_nfats;
    logic [31:0]  w_plba, w_fatsz, w_root;
    logic [32:0]  w_fat_sum, w_add_sum;
    logic         w_cap_en;

    assign rd.rd_start     = (state_q == ST_RD_MBR) || (state_q == ST_RD_BPB);
    assign rd.rd_sector_no = (state_q == ST_RD_BPB) ? part_q : 32'd0;
    assign w_cap_en        = rd.rvalid && rd.rd_start;

    le32_field_capture #(.OFFSET(OFS_SIG0),     .NBYTES(2)) u_sig   (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_sig));
    le32_field_capture #(.OFFSET(OFS_PTYPE),    .NBYTES(1)) u_ptype (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_ptype));
    le32_field_capture #(.OFFSET(OFS_PLBA),     .NBYTES(4)) u_plba  (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_plba));
    le32_field_capture #(.OFFSET(OFS_BPS),      .NBYTES(2)) u_bps   (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_bps));
    le32_field_capture #(.OFFSET(OFS_SPC),      .NBYTES(1)) u_spc   (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_spc));
    le32_field_capture #(.OFFSET(OFS_RSVD),     .NBYTES(2)) u_rsvd  (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_rsvd));
    le32_field_capture #(.OFFSET(OFS_NFATS),    .NBYTES(1)) u_nfats (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_nfats));
    le32_field_capture #(.OFFSET(OFS_FATSZ),    .NBYTES(4)) u_fatsz (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_fatsz));
    le32_field_capture #(.OFFSET(OFS_ROOTCLUS), .NBYTES(4)) u_root  (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_root));
`ifdef FAT32_PROBE_SUPERFLOPPY_EN
    logic [7:0] w_b0;
    le32_field_capture #(.OFFSET(OFS_JMP),      .NBYTES(1)) u_b0    (.clk(clk), .rst_n(rst_n), .clr_i(clr_cap), .en_i(w_cap_en), .addr_i(rd.raddr), .data_i(rd.rdata), .value_o(w_b0));
`endif

    // Bit 32 of each sum is the carry that flags a geometry overflow.
    assign w_fat_sum = {1'b0, part_q} + {17'd0, w_rsvd};
    assign w_add_sum = {1'b0, data_q} + {1'b0, w_fatsz};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        part_d     = part_q;
        err_d      = ERR_NONE;
        accept     = 1'b0;
        clr_cap    = 1'b0;
        load_fat   = 1'b0;
        do_add     = 1'b0;
        fin        = 1'b0;
        fail_final = 1'b0;
        retry      = 1'b0;
        set_err    = 1'b0;
        case (state_q)
            ST_IDLE: if (probe_start_i) begin
                accept  = 1'b1;
                clr_cap = 1'b1;
                part_d  = 32'd0;
                state_d = ST_RD_MBR;
            end
            ST_RD_MBR: if (rd.rd_done) state_d = ST_CHK_MBR;
            ST_CHK_MBR: begin
                if (w_sig != BOOT_SIG) begin
                    set_err = 1'b1; err_d = ERR_MBR_SIG; state_d = ST_FAIL;
                end else if (w_ptype == PTYPE_FAT32_CHS || w_ptype == PTYPE_FAT32_LBA) begin
                    part_d  = w_plba;
                    state_d = ST_RD_BPB;
                end
`ifdef FAT32_PROBE_SUPERFLOPPY_EN
                else if ((w_b0 == JMP_SHORT || w_b0 == JMP_NEAR) && w_bps == SECTOR_BYTES) begin
                    part_d  = 32'd0;
                    state_d = ST_CHK_BPB;
                end
`endif
                else begin
                    set_err = 1'b1; err_d = ERR_PTYPE; state_d = ST_FAIL;
                end
            end
            ST_RD_BPB: if (rd.rd_done) state_d = ST_CHK_BPB;
            ST_CHK_BPB: begin
                state_d = ST_FAIL;
                set_err = 1'b1;
                if (w_sig != BOOT_SIG)                        err_d = ERR_BPB_SIG;
                else if (w_bps != SECTOR_BYTES)               err_d = ERR_BPS;
                else if (!is_pow2(w_spc))                     err_d = ERR_SPC;
                else if (w_nfats == 8'd0 || w_fatsz == 32'd0) err_d = ERR_FATS;
                else if (w_fat_sum[32])                       err_d = ERR_OVERFLOW;
                else begin
                    set_err  = 1'b0;
                    load_fat = 1'b1;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_add_sum[32]) begin
                    set_err = 1'b1; err_d = ERR_OVERFLOW; state_d = ST_FAIL;
                end else begin
                    do_add = 1'b1;
                    if (cnt_q == 8'd1) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                fin     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                if (int'(retry_q) < MAX_RETRY) begin
                    retry   = 1'b1;
                    clr_cap = 1'b1;
                    state_d = ST_RD_MBR;
                end else begin
                    fail_final = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q  <= 32'd0;
            fat_q   <= 32'd0;
            data_q  <= 32'd0;
            cnt_q   <= 8'd0;
            retry_q <= 8'd0;
            err_q   <= ERR_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            part_q <= part_d;
            if (accept) begin
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
                error_q <= 1'b0;
                err_q   <= ERR_NONE;
                retry_q <= 8'd0;
                fat_q   <= 32'd0;
                data_q  <= 32'd0;
            end
            if (retry)   retry_q <= retry_q + 8'd1;
            if (set_err) err_q   <= err_d;
            if (load_fat) begin
                fat_q  <= w_fat_sum[31:0];
                data_q <= w_fat_sum[31:0];
                cnt_q  <= w_nfats;
            end
            if (do_add) begin
                data_q <= w_add_sum[31:0];
                cnt_q  <= cnt_q - 8'd1;
            end
            if (fin) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
            if (fail_final) begin
                error_q <= 1'b1;
                busy_q  <= 1'b0;
            end
        end
    end

    // Results are only presented once the probe has completed successfully.
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_code_o     = error_q ? err_q : ERR_NONE;
    assign part_lba_o     = done_q ? part_q : 32'd0;
    assign fat_lba_o      = done_q ? fat_q  : 32'd0;
    assign data_lba_o     = done_q ? data_q : 32'd0;
    assign root_clus_o    = done_q ? w_root : 32'd0;
    assign sec_per_clus_o = done_q ? w_spc  : 8'd0;

endmodule

`default_nettype wire

// File: tb/tb_fat32_volume_probe.sv
// ============================================================================
// Module   : tb_fat32_volume_probe
// Purpose  : Scoreboard bench with a behavioural sector reader for the probe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fat32_volume_probe;

    typedef struct {
        logic        dn;
        logic        er;
        logic [2:0]  ec;
        logic [31:0] part;
        logic [31:0] fat;
        logic [31:0] data;
        logic [7:0]  spc;
        logic [31:0] root;
        int          nr;
        logic [31:0] s2;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        probe_start = 1'b0;
    logic        busy, done, error;
    logic [2:0]  err_code;
    logic [31:0] part_lba, fat_lba, data_lba, root_clus;
    logic [7:0]  spc;

    logic [7:0]  img0 [512];
    logic [7:0]  img1 [512];
    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          nreads = 0;
    int          byte_idx = 0;
    int          t_rddone = 0;
    logic [31:0] sec2 = 32'd0;
    bit          rev = 1'b0;

    fat32_volume_probe_if rdif();

    fat32_volume_probe #(.MAX_RETRY(0)) dut (
        .clk(clk), .rst_n(rst_n), .probe_start_i(probe_start), .rd(rdif),
        .busy_o(busy), .done_o(done), .error_o(error), .err_code_o(err_code),
        .part_lba_o(part_lba), .fat_lba_o(fat_lba), .data_lba_o(data_lba),
        .root_clus_o(root_clus), .sec_per_clus_o(spc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Behavioural SPI reader: streams a whole sector then pulses rd_done.
    initial begin
        logic [31:0] sec;
        int a;
        bit aborted;
        rdif.rd_done = 1'b0; rdif.rvalid = 1'b0; rdif.raddr = 9'd0; rdif.rdata = 8'd0;
        forever begin
            @(negedge clk);
            if (rst_n && rdif.rd_start) begin
                sec = rdif.rd_sector_no;
                nreads++;
                if (nreads == 2) sec2 = sec;
                aborted = 1'b0;
                for (int i = 0; i < 512; i++) begin
                    if (!rst_n) begin aborted = 1'b1; break; end
                    a = rev ? 511 - i : i;
                    rdif.rvalid = 1'b1;
                    rdif.raddr  = 9'(a);
                    rdif.rdata  = (sec == 32'd0) ? img0[a] : img1[a];
                    byte_idx    = i;
                    @(negedge clk);
                end
                rdif.rvalid = 1'b0;
                if (!aborted && rst_n) begin
                    rdif.rd_done = 1'b1;
                    t_rddone = cyc + 1;
                    @(negedge clk);
                    rdif.rd_done = 1'b0;
                end
            end
        end
    end

    // Monitor: a falling busy marks a completed probe.
    initial begin
        bit   pb;
        exp_t e;
        pb = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) pb = 1'b0;
            else begin
                if (pb && !busy) begin
                    if (sb.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_completion: got done=%b error=%b, expected no completion", done, error);
                    end else begin
                        e = sb.pop_front();
                        chk("done", 32'(done), 32'(e.dn));
                        chk("error", 32'(error), 32'(e.er));
                        chk("err_code", 32'(err_code), 32'(e.ec));
                        chk("part_lba", part_lba, e.part);
                        chk("fat_lba", fat_lba, e.fat);
                        chk("data_lba", data_lba, e.data);
                        chk("sec_per_clus", 32'(spc), 32'(e.spc));
                        chk("root_clus", root_clus, e.root);
                        chk("sector_reads", 32'(nreads), 32'(e.nr));
                        if (e.nr == 2) chk("second_sector_no", sec2, e.s2);
                        if (e.lat >= 0) chk("latency", 32'(cyc - t_rddone), 32'(e.lat));
                    end
                end
                pb = busy;
            end
        end
    end

    function automatic exp_t ok(logic [31:0] p, logic [31:0] f, logic [31:0] d, logic [7:0] s,
                                logic [31:0] r, int nr, logic [31:0] s2, int lat);
        exp_t e;
        e.dn = 1'b1; e.er = 1'b0; e.ec = 3'd0; e.part = p; e.fat = f; e.data = d;
        e.spc = s; e.root = r; e.nr = nr; e.s2 = s2; e.lat = lat;
        return e;
    endfunction

    function automatic exp_t err(logic [2:0] c, int nr, logic [31:0] s2);
        exp_t e;
        e.dn = 1'b0; e.er = 1'b1; e.ec = c; e.part = 0; e.fat = 0; e.data = 0;
        e.spc = 0; e.root = 0; e.nr = nr; e.s2 = s2; e.lat = -1;
        return e;
    endfunction

    task automatic put(input int sel, input int a, input logic [7:0] v);
        if (sel == 0) img0[a] = v;
        else          img1[a] = v;
    endtask

    task automatic mk_mbr(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] pt,
                          input logic [31:0] lba);
        for (int i = 0; i < 512; i++) img0[i] = 8'd0;
        img0[0]   = 8'h33;
        img0[450] = pt;
        for (int i = 0; i < 4; i++) img0[454 + i] = lba[8*i +: 8];
        img0[510] = s0;
        img0[511] = s1;
    endtask

    task automatic mk_bpb(input int sel, input logic [7:0] b0, input logic [15:0] bps,
                          input logic [7:0] sp, input logic [15:0] rsvd, input logic [7:0] nf,
                          input logic [31:0] fsz, input logic [31:0] root,
                          input logic [7:0] s0, input logic [7:0] s1);
        if (sel == 1) for (int i = 0; i < 512; i++) img1[i] = 8'd0;
        put(sel, 0, b0);
        put(sel, 11, bps[7:0]);  put(sel, 12, bps[15:8]);
        put(sel, 13, sp);
        put(sel, 14, rsvd[7:0]); put(sel, 15, rsvd[15:8]);
        put(sel, 16, nf);
        for (int i = 0; i < 4; i++) begin
            put(sel, 36 + i, fsz[8*i +: 8]);
            put(sel, 44 + i, root[8*i +: 8]);
        end
        put(sel, 510, s0);
        put(sel, 511, s1);
    endtask

    task automatic pulse_start();
        @(negedge clk); probe_start = 1'b1;
        @(negedge clk); probe_start = 1'b0;
    endtask

    task automatic run(input exp_t e, input bit glitch);
        int k;
        nreads = 0; sec2 = 32'd0;
        sb.push_back(e);
        pulse_start();
        if (glitch) begin
            repeat (50) @(negedge clk);
            pulse_start();
        end
        k = 0;
        while (sb.size() != 0 && k < 5000) begin @(negedge clk); k++; end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL completion_timeout: got busy=%b after %0d cycles, expected completion", busy, k);
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
        chk({tag, "_rd_start"}, 32'(rdif.rd_start), 32'd0);
        chk({tag, "_part_lba"}, part_lba, 32'd0);
        chk({tag, "_data_lba"}, data_lba, 32'd0);
        chk({tag, "_sec_per_clus"}, 32'(spc), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

    initial begin
        int k;
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal partitioned card, with a probe_start dropped while busy
        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'h0000_2000);
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(ok(32'h2000, 32'h2020, 32'h27A2, 8'd8, 32'd2, 2, 32'h2000, 4), 1'b1);

        mk_mbr(8'h55, 8'hAB, 8'h0C, 32'h0000_2000);
        run(err(3'd1, 1, 0), 1'b0);

        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'h0000_2000);
        mk_bpb(1, 8'hEB, 16'd512, 8'd6, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(err(3'd5, 2, 32'h2000), 1'b0);

        // Corrected image, three FATs, bytes delivered in reverse order
        rev = 1'b1;
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd3, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(ok(32'h2000, 32'h2020, 32'h2B63, 8'd8, 32'd2, 2, 32'h2000, 5), 1'b0);
        rev = 1'b0;

        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'hFFFF_FFF0);
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'h20, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(err(3'd7, 2, 32'hFFFF_FFF0), 1'b0);

        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'h10);
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'h20, 8'd2, 32'h8000_0000, 32'd2, 8'h55, 8'hAA);
        run(err(3'd7, 2, 32'h10), 1'b0);

        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'h800);
        mk_bpb(1, 8'hEB, 16'd1024, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(err(3'd4, 2, 32'h800), 1'b0);

        mk_bpb(1, 8'hEB, 16'd1024, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'h00);
        run(err(3'd3, 2, 32'h800), 1'b0);

        mk_mbr(8'h55, 8'hAA, 8'h0B, 32'h800);
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd0, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        run(err(3'd6, 2, 32'h800), 1'b0);

        mk_bpb(1, 8'hEB, 16'd512, 8'd16, 16'd32, 8'd2, 32'd0, 32'd2, 8'h55, 8'hAA);
        run(err(3'd6, 2, 32'h800), 1'b0);

        mk_mbr(8'h55, 8'hAA, 8'h07, 32'h800);
        run(err(3'd2, 1, 0), 1'b0);

        // Superfloppy: no partition table, BPB lives in sector 0
        mk_mbr(8'h55, 8'hAA, 8'h00, 32'h0);
        mk_bpb(0, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
`ifdef FAT32_PROBE_SUPERFLOPPY_EN
        run(ok(32'h0, 32'h20, 32'h7A2, 8'd8, 32'd2, 1, 32'h0, 5), 1'b0);
`else
        run(err(3'd2, 1, 0), 1'b0);
`endif

        // Reset during byte 100 of the BPB read, then a clean probe
        mk_mbr(8'h55, 8'hAA, 8'h0C, 32'h0000_2000);
        mk_bpb(1, 8'hEB, 16'd512, 8'd8, 16'd32, 8'd2, 32'h3C1, 32'd2, 8'h55, 8'hAA);
        nreads = 0;
        pulse_start();
        k = 0;
        while (!(nreads == 2 && byte_idx >= 100) && k < 5000) begin @(posedge clk); k++; end
        if (k >= 5000) begin
            n_chk++; n_fail++;
            $display("FAIL bpb_byte100_wait: got nreads=%0d byte=%0d, expected BPB byte 100", nreads, byte_idx);
        end
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run(ok(32'h2000, 32'h2020, 32'h27A2, 8'd8, 32'd2, 2, 32'h2000, 4), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
